comparer_serial: RTL and testbench

//  Parametrised multi-bit magnitude comparator. Successor to the single-bit a/b comparator.

---
 rtl/comparer_pkg.sv | 15 +
 rtl/comparer_chunk.sv | 16 +
 rtl/comparer_serial.sv | 112 +++++++++++
 tb/tb_comparer_serial.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/comparer_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and one-hot result codes.
// Result bit order matches the LED order {led3, led2, led1} = {gt, eq, lt}.
package comparer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [2:0] RES_LT = 3'b001;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b100;

endpackage

// File: rtl/comparer_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare; the N-bit form of the 1-bit a/b comparator.
module comparer_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_gt
);

  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/comparer_serial.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB slice first, CHUNK bits per
// clock, stopping at the first differing slice; the lt/eq/gt result is held on the LEDs.
module comparer_serial
  import comparer_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  input  logic                               signed_mode,
  output logic                               out_valid,
  output logic                               led1,
  output logic                               led2,
  output logic                               led3,
  output logic                               busy,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]   cycles
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = $clog2(NSLICE + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

  if (WIDTH < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("comparer_serial: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  state_e            r_state;
  state_e            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [CW-1:0]     r_idx;
  logic [2:0]        r_leds;
  logic [CW-1:0]     r_cycles;

  logic              w_accept;
  logic              w_eff_signed;
  logic [WIDTH-1:0]  w_sign_mask;
  logic              w_lt;
  logic              w_eq;
  logic              w_gt;
  logic              w_last;
  logic              w_finish;

  assign w_accept     = (r_state == IDLE) && in_valid;
  assign w_eff_signed = signed_mode && SIGNED_EN;
  // Flipping both sign bits maps two's complement onto offset binary, so every slice compares unsigned.
  assign w_sign_mask  = WIDTH'(w_eff_signed) << (WIDTH - 1);
  assign w_last       = (r_idx == LAST_IDX);
  assign w_finish     = (r_state == COMPARE) && (!w_eq || w_last);

  comparer_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a  (r_a[WIDTH-1 -: CHUNK]),
    .i_b  (r_b[WIDTH-1 -: CHUNK]),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = COMPARE;
      COMPARE: if (!w_eq || w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_leds   <= 3'b000;
      r_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_finish) begin
        r_leds   <= w_lt ? RES_LT : (w_gt ? RES_GT : RES_EQ);
        r_cycles <= r_idx + CW'(1);
      end
    end
  end

  // NOTE: the operand shifters and slice index are always loaded on acceptance before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= a ^ w_sign_mask;
      r_b   <= b ^ w_sign_mask;
      r_idx <= '0;
    end else if (r_state == COMPARE && !w_finish) begin
      r_a   <= r_a << CHUNK;
      r_b   <= r_b << CHUNK;
      r_idx <= r_idx + CW'(1);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == COMPARE);
  assign out_valid = (r_state == DONE);
  assign led1      = r_leds[0];
  assign led2      = r_leds[1];
  assign led3      = r_leds[2];
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_comparer_serial.sv
// Bench for comparer_serial: directed cases plus random operands checked against an
// arithmetic reference model, on a 16/4 signed-capable instance and an 8/8 unsigned-only one.
module tb_comparer_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: WIDTH=16, CHUNK=4, SIGNED_EN=1
  logic        rst0 = 1'b1, iv0 = 1'b0, sm0 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0;
  logic        ir0, ov0, l1_0, l2_0, l3_0, bz0;
  logic [2:0]  cy0;

  // Instance 1: WIDTH=8, CHUNK=8, SIGNED_EN=0
  logic        rst1 = 1'b1, iv1 = 1'b0, sm1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        ir1, ov1, l1_1, l2_1, l3_1, bz1;
  logic [0:0]  cy1;

  comparer_serial #(.WIDTH(16), .CHUNK(4), .SIGNED_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .signed_mode(sm0), .out_valid(ov0), .led1(l1_0), .led2(l2_0), .led3(l3_0),
    .busy(bz0), .cycles(cy0)
  );

  comparer_serial #(.WIDTH(8), .CHUNK(8), .SIGNED_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .signed_mode(sm1), .out_valid(ov1), .led1(l1_1), .led2(l2_1), .led3(l3_1),
    .busy(bz1), .cycles(cy1)
  );

  // Selected-instance view so one set of tasks serves both DUTs.
  bit         sel = 1'b0;
  logic       m_ov, m_ir, m_bz;
  logic [2:0] m_leds, m_cy;
  assign m_ov   = sel ? ov1 : ov0;
  assign m_ir   = sel ? ir1 : ir0;
  assign m_bz   = sel ? bz1 : bz0;
  assign m_leds = sel ? {l3_1, l2_1, l1_1} : {l3_0, l2_0, l1_0};
  assign m_cy   = sel ? {2'b00, cy1} : cy0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic sm);
    if (sel) begin
      iv1 = v; a1 = a[7:0]; b1 = b[7:0]; sm1 = sm;
    end else begin
      iv0 = v; a0 = a; b0 = b; sm0 = sm;
    end
  endtask

  // Reference: compare as integers and locate the first differing slice from the top.
  function automatic void model(input int w, input int c, input bit sen,
                                input logic [15:0] a, input logic [15:0] b, input bit sm,
                                output logic [2:0] res, output int cyc);
    longint mask, ua, ub, sa, sb, diff;
    int n;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua;
    sb = ub;
    if (sm && sen) begin
      if (ua >= (longint'(1) << (w - 1))) sa = ua - (longint'(1) << w);
      if (ub >= (longint'(1) << (w - 1))) sb = ub - (longint'(1) << w);
    end
    res = (sa < sb) ? 3'b001 : (sa > sb) ? 3'b100 : 3'b010;
    n = w / c;
    cyc = n;
    diff = ua ^ ub;
    for (int k = 0; k < n; k++) begin
      if (((diff >> (w - (k + 1) * c)) & ((longint'(1) << c) - 1)) != 0) begin
        cyc = k + 1;
        break;
      end
    end
  endfunction

  task automatic run_cmp(input bit s, input logic [15:0] a, input logic [15:0] b, input bit sm,
                         input bit junk, input logic [2:0] exp_res, input int exp_cyc, input string tag);
    int n;
    bit seen;
    @(negedge clk);
    sel = s;
    drive(1'b1, a, b, sm);
    @(negedge clk);
    check({tag, "_busy"}, m_bz, 1);
    if (junk) drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    else      drive(1'b0, a, b, sm);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (m_ov) seen = 1'b1;
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    check({tag, "_latency"}, seen ? n : 0, exp_cyc);
    check({tag, "_leds"}, m_leds, exp_res);
    check({tag, "_cycles"}, m_cy, exp_cyc);
    check({tag, "_ready_done"}, m_ir, 0);
    @(negedge clk);
    check({tag, "_pulse_end"}, m_ov, 0);
    check({tag, "_ready_idle"}, m_ir, 1);
    check({tag, "_leds_held"}, m_leds, exp_res);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [2:0]  er;
    int          ec;
    bit          rs;
    int          seen_pulse;

    // 1. reset / idle state on both instances
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    check("rst_leds", m_leds, 3'b000);
    check("rst_out_valid", m_ov, 0);
    check("rst_cycles", m_cy, 0);
    check("rst_ready", m_ir, 1);
    check("rst_busy", m_bz, 0);
    sel = 1'b1;
    check("rst1_leds", m_leds, 3'b000);
    check("rst1_ready", m_ir, 1);
    rst0 = 1'b0; rst1 = 1'b0;

    // 2-4. directed cases on the 16/4 instance
    run_cmp(0, 16'h1234, 16'h1234, 0, 0, 3'b010, 4, "eq_unsigned");
    run_cmp(0, 16'h8000, 16'h7FFF, 0, 0, 3'b100, 1, "msb_unsigned");
    run_cmp(0, 16'h8000, 16'h7FFF, 1, 0, 3'b001, 1, "msb_signed");
    run_cmp(0, 16'h1235, 16'h1234, 0, 0, 3'b100, 4, "last_slice_gt");
    run_cmp(0, 16'h1204, 16'h1214, 0, 0, 3'b001, 3, "slice3_lt");
    run_cmp(0, 16'hFFFF, 16'hFFFE, 1, 0, 3'b100, 4, "neg1_vs_neg2");
    run_cmp(0, 16'h0000, 16'h0000, 1, 0, 3'b010, 4, "zero_eq_signed");

    // 5. in_valid held with other operands while busy must be ignored
    run_cmp(0, 16'h0001, 16'h0002, 0, 1, 3'b001, 4, "busy_ignore");

    // 5b. reset on the second compare cycle: back to IDLE, LEDs cleared, no pulse
    @(negedge clk);
    sel = 1'b0;
    drive(1'b1, 16'h0001, 16'h0002, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    check("abort_in_compare", m_bz, 1);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("abort_ready", m_ir, 1);
    check("abort_busy", m_bz, 0);
    check("abort_leds", m_leds, 3'b000);
    check("abort_out_valid", m_ov, 0);
    seen_pulse = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_ov) seen_pulse++;
    end
    check("abort_no_pulse", seen_pulse, 0);

    // 6. single-slice instance, unsigned only
    run_cmp(1, 16'h0005, 16'h0009, 0, 0, 3'b001, 1, "w8_lt");
    run_cmp(1, 16'h0080, 16'h007F, 1, 0, 3'b100, 1, "w8_signed_ignored");
    run_cmp(1, 16'h00A5, 16'h00A5, 1, 0, 3'b010, 1, "w8_eq");

    // random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'h1 << $urandom_range(0, 15));
      endcase
      rs = 1'($urandom);
      model(16, 4, 1'b1, ra, rb, rs, er, ec);
      run_cmp(0, ra, rb, rs, 1'($urandom), er, ec, "rand16");
    end
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom_range(0, 255));
      rs = 1'($urandom);
      model(8, 8, 1'b0, ra, rb, rs, er, ec);
      run_cmp(1, ra, rb, rs, 0, er, ec, "rand8");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
